// File: rtl/keypad_matrix_scanner.sv
// rtl/keypad_matrix_scanner.sv - matrix keypad scanner with debounce and press/release event handshake
module keypad_matrix_scanner #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 100000,
    parameter int DEBOUNCE = 3,
    localparam int CODE_W  = $clog2(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ROWS-1:0]   row,
    output logic [COLS-1:0]   col,
    output logic              key_valid,
    output logic [CODE_W-1:0] key_code,
    output logic              key_release,
    input  logic              key_ack,
    output logic              key_down,
    output logic              overflow,
    input  logic              clr_ovf
);
    localparam int N     = ROWS * COLS;
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(COLS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE);
    localparam logic [CODE_W-1:0] CODE_LAST = CODE_W'(N - 1);

    typedef enum logic [1:0] {IDLE, SEARCH, HOLD} state_t;

    state_t            state;
    logic [ROWS-1:0]   row_meta;
    logic [ROWS-1:0]   row_sync;
    logic [DIV_W-1:0]  div;
    logic [IDX_W-1:0]  col_idx;
    logic [N-1:0]      raw;
    logic [N-1:0]      cand;
    logic [N-1:0]      debounced;
    logic [N-1:0]      reported;
    logic [CNT_W-1:0]  cnt;
    logic [CODE_W-1:0] search_idx;

    logic              step;
    logic              frame_end;
    logic [IDX_W-1:0]  idx_next;
    logic [COLS-1:0]   col_next;
    logic [N-1:0]      raw_next;
    logic [N-1:0]      cand_next;
    logic [CNT_W-1:0]  cnt_next;
    logic              deb_update;
    logic              ovf_set;

    // raw_next folds in the column being latched this cycle, so the frame-end
    // comparison sees the complete frame rather than the previous one.
    always_comb begin
        step      = (div == DIV_LAST);
        frame_end = step && (col_idx == IDX_LAST);
        idx_next  = (col_idx == IDX_LAST) ? '0 : col_idx + 1'b1;
        col_next  = '1;
        for (int c = 0; c < COLS; c++) begin
            if (IDX_W'(c) == idx_next) begin
                col_next[c] = 1'b0;
            end
        end
        raw_next = raw;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (IDX_W'(c) == col_idx) begin
                    raw_next[r*COLS+c] = ~row_sync[r];
                end
            end
        end
        if (raw_next == cand) begin
            cand_next = cand;
            cnt_next  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        end else begin
            cand_next = raw_next;
            cnt_next  = CNT_W'(1);
        end
        deb_update = frame_end && (cnt_next == CNT_MAX) && (cand_next != debounced);
        // A bit flipping back before its previous change was reported is a lost event pair.
        ovf_set    = deb_update && (|((debounced ^ cand_next) & (reported ^ debounced)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_meta    <= '1;
            row_sync    <= '1;
            div         <= '0;
            col_idx     <= '0;
            col         <= ~COLS'(1);
            raw         <= '0;
            cand        <= '0;
            debounced   <= '0;
            reported    <= '0;
            cnt         <= CNT_MAX;
            state       <= IDLE;
            search_idx  <= '0;
            key_valid   <= 1'b0;
            key_code    <= '0;
            key_release <= 1'b0;
            key_down    <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;

            if (step) begin
                div     <= '0;
                col_idx <= idx_next;
                col     <= col_next;
                raw     <= raw_next;
            end else begin
                div <= div + 1'b1;
            end

            if (frame_end) begin
                cand <= cand_next;
                cnt  <= cnt_next;
                if (deb_update) begin
                    debounced <= cand_next;
                end
            end

            key_down <= |debounced;

            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if ((debounced != reported) && !key_valid) begin
                        search_idx <= '0;
                        state      <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (debounced[search_idx] != reported[search_idx]) begin
                        key_code             <= search_idx;
                        key_release          <= ~debounced[search_idx];
                        reported[search_idx] <= debounced[search_idx];
                        key_valid            <= 1'b1;
                        state                <= HOLD;
                    end else if (search_idx == CODE_LAST) begin
                        state <= IDLE;
                    end else begin
                        search_idx <= search_idx + 1'b1;
                    end
                end
                HOLD: begin
                    if (key_ack) begin
                        key_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb/tb_keypad_matrix_scanner.sv - directed bench with frame-level keypad model for keypad_matrix_scanner
module tb_keypad_matrix_scanner;
    localparam int N = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_release;
    logic        key_ack = 1'b0;
    logic        key_down;
    logic        overflow;
    logic        clr_ovf = 1'b0;
    logic [15:0] held = '0;

    int checks = 0;
    int errors = 0;

    keypad_matrix_scanner #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3)
    ) dut (
        .clk(clk), .reset(reset), .row(row), .col(col),
        .key_valid(key_valid), .key_code(key_code), .key_release(key_release),
        .key_ack(key_ack), .key_down(key_down), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    // Physical keypad: a held key pulls its row low while its column is driven low.
    always_comb begin
        row = '1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!col[c] && held[r*4+c]) row[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Keypad model, evaluated once per clock after each edge.
    bit          model_ok = 0;
    int          t = 0;
    logic [15:0] m_raw, m_cand, m_deb, m_rep;
    int          m_cnt;
    logic        m_ovf;
    logic        p_reset = 1'b0, p_ack = 1'b0, p_clr = 1'b0, p_valid = 1'b0;
    logic [15:0] h_a = '0, h_b = '0, h_c = '0;
    logic [3:0]  hold_code;
    logic        hold_rel;
    int          wait_cnt;

    always @(negedge clk) begin
        logic [15:0] deb_old, rep_old;
        logic [3:0]  exp_col;
        logic        set;
        int          tb, cix, lowest;
        if (p_reset) begin
            model_ok = 1; t = 0;
            m_raw = '0; m_cand = '0; m_deb = '0; m_rep = '0; m_cnt = 3; m_ovf = 1'b0;
            p_valid = 1'b0; wait_cnt = 0;
            check("rst_valid", key_valid, 0);
            check("rst_code", key_code, 0);
            check("rst_release", key_release, 0);
            check("rst_key_down", key_down, 0);
            check("rst_overflow", overflow, 0);
            check("rst_col", col, 4'hE);
        end else if (model_ok) begin
            tb = t; t++;
            cix = (tb / 4) % 4;
            if (tb % 4 == 3) begin
                // Rows seen at a column step reflect the keys two clocks earlier.
                for (int r = 0; r < 4; r++) m_raw[r*4+cix] = h_c[r*4+cix];
            end
            deb_old = m_deb; rep_old = m_rep; set = 1'b0;
            if (tb % 16 == 15) begin
                if (m_raw == m_cand) begin
                    if (m_cnt < 3) m_cnt++;
                end else begin
                    m_cand = m_raw; m_cnt = 1;
                end
                if (m_cnt == 3 && m_cand != m_deb) begin
                    if (|((m_deb ^ m_cand) & (m_rep ^ m_deb))) set = 1'b1;
                    m_deb = m_cand;
                end
            end
            check("key_down", key_down, |deb_old);
            if (set) m_ovf = 1'b1;
            else if (p_clr) m_ovf = 1'b0;
            check("overflow", overflow, m_ovf);
            exp_col = ~(4'b0001 << ((t / 4) % 4));
            check("col", col, exp_col);

            if (p_valid) begin
                if (p_ack) begin
                    check("valid_after_ack", key_valid, 0);
                end else begin
                    check("hold_valid", key_valid, 1);
                    check("hold_code", key_code, hold_code);
                    check("hold_release", key_release, hold_rel);
                end
                wait_cnt = 0;
            end else if (key_valid) begin
                lowest = -1;
                for (int i = 0; i < N; i++) begin
                    if (lowest < 0 && deb_old[i] != rep_old[i]) lowest = i;
                end
                check("event_pending", lowest >= 0, 1);
                if (lowest >= 0) begin
                    hold_code = 4'(lowest);
                    hold_rel  = ~deb_old[lowest];
                    check("event_code", key_code, hold_code);
                    check("event_release", key_release, hold_rel);
                    m_rep[lowest] = deb_old[lowest];
                end
                wait_cnt = 0;
            end else begin
                if (m_deb != m_rep) wait_cnt++;
                else wait_cnt = 0;
                check("event_latency", wait_cnt > N + 2, 0);
            end
            p_valid = key_valid;
        end
        p_reset = reset; p_ack = key_ack; p_clr = clr_ovf;
        h_c = h_b; h_b = h_a; h_a = held;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max, input string name);
        int n = 0;
        while (!key_valid && n < max) begin
            tick(1);
            n++;
        end
        check({name, "_seen"}, key_valid, 1);
    endtask

    task automatic do_ack();
        key_ack = 1'b1;
        tick(1);
        key_ack = 1'b0;
        check("ack_drop", key_valid, 0);
    endtask

    task automatic quiet(input int n, input string name);
        int seen = 0;
        repeat (n) begin
            tick(1);
            if (key_valid) seen++;
        end
        check({name, "_no_event"}, seen, 0);
    endtask

    initial begin
        // 1: reset and column walk
        tick(3);
        reset = 1'b0;
        check("col_0", col, 4'hE);
        tick(4); check("col_1", col, 4'hD);
        tick(4); check("col_2", col, 4'hB);
        tick(4); check("col_3", col, 4'h7);
        tick(4); check("col_wrap", col, 4'hE);
        check("idle_valid", key_valid, 0);
        check("idle_overflow", overflow, 0);
        check("idle_key_down", key_down, 0);

        // 2: single press and release of key 6
        held[6] = 1'b1;
        wait_valid(6 * 16 + 20, "press6");
        check("press6_code", key_code, 6);
        check("press6_release", key_release, 0);
        check("press6_key_down", key_down, 1);
        do_ack();
        held[6] = 1'b0;
        wait_valid(6 * 16 + 20, "rel6");
        check("rel6_code", key_code, 6);
        check("rel6_release", key_release, 1);
        check("rel6_key_down", key_down, 0);
        do_ack();

        // 3: two-frame bounce is rejected; stray ack is ignored
        tick(20);
        held[6] = 1'b1;
        tick(32);
        held[6] = 1'b0;
        key_ack = 1'b1;
        tick(1);
        key_ack = 1'b0;
        quiet(6 * 16, "bounce");
        check("bounce_overflow", overflow, 0);
        check("bounce_key_down", key_down, 0);

        // 4: simultaneous presses reported in ascending order, one per ack
        held[1] = 1'b1; held[14] = 1'b1;
        wait_valid(6 * 16 + 20, "multi1");
        check("multi1_code", key_code, 1);
        check("multi1_release", key_release, 0);
        tick(40);
        check("multi1_still_valid", key_valid, 1);
        check("multi1_still_code", key_code, 1);
        do_ack();
        wait_valid(40, "multi14");
        check("multi14_code", key_code, 14);
        check("multi14_release", key_release, 0);
        do_ack();
        held[1] = 1'b0; held[14] = 1'b0;
        wait_valid(6 * 16 + 20, "multi_rel1");
        check("multi_rel1_code", key_code, 1);
        check("multi_rel1_release", key_release, 1);
        do_ack();
        wait_valid(40, "multi_rel14");
        check("multi_rel14_code", key_code, 14);
        check("multi_rel14_release", key_release, 1);
        do_ack();

        // 5: press and release of key 5 lost behind an unacked event
        held[0] = 1'b1;
        wait_valid(6 * 16 + 20, "blk0");
        check("blk0_code", key_code, 0);
        held[5] = 1'b1;
        tick(5 * 16);
        held[5] = 1'b0;
        tick(5 * 16);
        check("lost_overflow", overflow, 1);
        check("lost_hold_valid", key_valid, 1);
        check("lost_hold_code", key_code, 0);
        do_ack();
        quiet(3 * 16, "lost5");
        check("ovf_sticky", overflow, 1);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        check("ovf_cleared", overflow, 0);
        held[0] = 1'b0;
        wait_valid(6 * 16 + 20, "rel0");
        check("rel0_code", key_code, 0);
        check("rel0_release", key_release, 1);
        do_ack();

        // 6: reset during hold discards the event
        held[9] = 1'b1;
        wait_valid(6 * 16 + 20, "press9");
        check("press9_code", key_code, 9);
        reset = 1'b1;
        held = '0;
        tick(1);
        check("rst_hold_valid", key_valid, 0);
        check("rst_hold_col", col, 4'hE);
        reset = 1'b0;
        quiet(6 * 16, "post_reset");
        check("post_reset_key_down", key_down, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        errors++;
        $display("FAIL timeout actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
